fpu_div_iter: RTL and testbench

Multi-cycle IEEE-754 single-precision divider serving FDIV.S requests from the execute stage. The pipeline initiates with a one-cycle start pulse and stalls while `o_busy` is high. This block responds with a registered quotient, a one-cycle `o_valid` pulse and RISC-V exception flags. Its result is steered onto the same writeback path as the combinational ALU/FPU result.

---
 rtl/fpu_div_iter.sv | 134 +++++++++++++
 tb/tb_fpu_div_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_iter.sv
// fpu_div_iter: multi-cycle IEEE-754 single-precision divider.
// Uses restoring significand division, round-to-nearest-even and flush-to-zero.
module fpu_div_iter #(
    parameter int DIV_BITS = 26
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [31:0] i_rs1_f,
    input  logic [31:0] i_rs2_f,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_fpu_data,
    output logic [4:0]  o_fflags
);
    localparam int CW = $clog2(DIV_BITS);
    localparam logic [DIV_BITS-1:0] LOW_MASK = (DIV_BITS'(1) << (DIV_BITS - 25)) - DIV_BITS'(1);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    state_t state, state_d;

    logic                sign, special;
    logic [7:0]          ea, eb;
    logic [23:0]         mb;
    logic [24:0]         rem, diff;
    logic [DIV_BITS-1:0] quo, qn;
    logic [CW-1:0]       cnt;
    logic [31:0]         sp_data_q;
    logic [4:0]          sp_flags_q;
    logic                ge;

    logic [7:0]  a_exp, b_exp;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nv, sp_any, sp_sign;
    logic [31:0] sp_data;
    logic [4:0]  sp_flags;

    logic               norm, guard, sticky, rnd, ovf, unf;
    logic [23:0]        mant;
    logic [24:0]        mant_r;
    logic [22:0]        frac;
    logic signed [9:0]  exp_r;
    logic [31:0]        res;
    logic [4:0]         flg;

    // Subnormal operands are treated as zero, so exponent 0 alone means zero.
    assign a_exp   = i_rs1_f[30:23];
    assign b_exp   = i_rs2_f[30:23];
    assign a_zero  = a_exp == 8'h00;
    assign b_zero  = b_exp == 8'h00;
    assign a_nan   = (&a_exp) & (|i_rs1_f[22:0]);
    assign b_nan   = (&b_exp) & (|i_rs2_f[22:0]);
    assign a_inf   = (&a_exp) & ~(|i_rs1_f[22:0]);
    assign b_inf   = (&b_exp) & ~(|i_rs2_f[22:0]);
    assign sp_sign = i_rs1_f[31] ^ i_rs2_f[31];
    assign nv      = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign sp_any  = nv | a_inf | b_inf | a_zero | b_zero;
    assign sp_data = nv ? 32'h7FC0_0000 :
                     (a_inf | b_zero) ? {sp_sign, 8'hFF, 23'd0} : {sp_sign, 31'd0};
    assign sp_flags = nv ? 5'b10000 : (b_zero & ~a_inf) ? 5'b01000 : 5'b00000;

    assign ge   = rem >= {1'b0, mb};
    assign diff = ge ? rem - {1'b0, mb} : rem;

    // Quotient lies in [0.5, 2): a clear MSB means one extra left shift.
    assign norm   = quo[DIV_BITS-1];
    assign qn     = norm ? quo : quo << 1;
    assign mant   = qn[DIV_BITS-1 -: 24];
    assign guard  = qn[DIV_BITS-25];
    assign sticky = (|rem) | (|(qn & LOW_MASK));
    assign rnd    = guard & (sticky | mant[0]);
    assign mant_r = {1'b0, mant} + {24'd0, rnd};
    assign frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    assign exp_r  = $signed({2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, ~norm} + {9'd0, mant_r[24]});
    assign ovf    = exp_r >= 10'sd255;
    assign unf    = exp_r <= 10'sd0;
    assign res    = ovf ? {sign, 8'hFF, 23'd0} : unf ? {sign, 31'd0} : {sign, exp_r[7:0], frac};
    assign flg    = ovf ? 5'b00101 : unf ? 5'b00011 : {4'b0000, guard | sticky};

    assign o_busy = state != IDLE;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (i_start && !i_flush) state_d = sp_any ? ROUND : DIV;
            DIV:     state_d = i_flush ? IDLE : (cnt == CW'(DIV_BITS - 1)) ? ROUND : DIV;
            ROUND:   state_d = i_flush ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            sign       <= 1'b0;
            special    <= 1'b0;
            ea         <= '0;
            eb         <= '0;
            mb         <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            sp_data_q  <= '0;
            sp_flags_q <= '0;
            o_valid    <= 1'b0;
            o_fpu_data <= '0;
            o_fflags   <= '0;
        end else begin
            state   <= state_d;
            o_valid <= (state == ROUND) && !i_flush;
            if (state == IDLE && i_start && !i_flush) begin
                sign       <= sp_sign;
                ea         <= a_exp;
                eb         <= b_exp;
                mb         <= {1'b1, i_rs2_f[22:0]};
                rem        <= {2'b01, i_rs1_f[22:0]};
                quo        <= '0;
                cnt        <= '0;
                special    <= sp_any;
                sp_data_q  <= sp_data;
                sp_flags_q <= sp_flags;
            end
            if (state == DIV) begin
                rem <= diff << 1;
                quo <= {quo[DIV_BITS-2:0], ge};
                cnt <= cnt + 1'b1;
            end
            if (state == ROUND && !i_flush) begin
                o_fpu_data <= special ? sp_data_q : res;
                o_fflags   <= special ? sp_flags_q : flg;
            end
        end
    end
endmodule

// File: tb/tb_fpu_div_iter.sv
// tb_fpu_div_iter: scoreboard bench for the iterative FP divider.
module tb_fpu_div_iter;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_rs1_f = '0;
    logic [31:0] i_rs2_f = '0;
    logic        o_busy, o_valid;
    logic [31:0] o_fpu_data;
    logic [4:0]  o_fflags;

    int compared = 0;
    int mismatched = 0;

    typedef struct { logic [31:0] d; logic [4:0] f; int lat; } exp_t;
    exp_t sb[$];

    always #5 i_clk = ~i_clk;

    fpu_div_iter #(.DIV_BITS(26)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_flush(i_flush),
        .i_rs1_f(i_rs1_f), .i_rs2_f(i_rs2_f), .o_busy(o_busy), .o_valid(o_valid),
        .o_fpu_data(o_fpu_data), .o_fflags(o_fflags)
    );

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_rs1_f = a; i_rs2_f = b;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_valid(output logic [31:0] d, output logic [4:0] f, output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin @(posedge i_clk); #1; lat++; end
        if (!o_valid) lat = -1;
        d = o_fpu_data;
        f = o_fflags;
    endtask

    task automatic test_reset();
        #12;
        compared += 4;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b want 0", o_busy); end
        if (o_valid !== 1'b0) begin mismatched++; $display("FAIL reset valid: got %b want 0", o_valid); end
        if (o_fpu_data !== 32'h0) begin mismatched++; $display("FAIL reset data: got %h want 00000000", o_fpu_data); end
        if (o_fflags !== 5'b0) begin mismatched++; $display("FAIL reset flags: got %b want 00000", o_fflags); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
    endtask

    task automatic test_exact();
        logic [31:0] d; logic [4:0] f; int lat; exp_t e;
        sb.push_back('{32'h4040_0000, 5'b00000, 27});
        send(32'h40C0_0000, 32'h4000_0000);
        wait_valid(d, f, lat);
        e = sb.pop_front();
        compared += 3;
        if (d !== e.d) begin mismatched++; $display("FAIL exact data: got %h want %h", d, e.d); end
        if (f !== e.f) begin mismatched++; $display("FAIL exact flags: got %b want %b", f, e.f); end
        if (lat != e.lat) begin mismatched++; $display("FAIL exact latency: got %0d want %0d", lat, e.lat); end
        @(posedge i_clk); #1;
        compared++;
        if (o_valid !== 1'b0) begin mismatched++; $display("FAIL exact pulse width: valid got %b want 0", o_valid); end
    endtask

    task automatic test_normals();
        logic [31:0] ta [8], tb [8], td [8];
        logic [4:0]  tf [8];
        logic [31:0] d; logic [4:0] f; int lat; exp_t e;
        ta = '{32'h3F80_0000, 32'h3F80_0000, 32'hC0C0_0000, 32'h4000_0000,
               32'h4000_0000, 32'h7F00_0000, 32'hFF00_0000, 32'h0080_0000};
        tb = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000,
               32'h4040_0000, 32'h3E80_0000, 32'h3E80_0000, 32'h4000_0000};
        td = '{32'h3EAA_AAAB, 32'h3F80_0000, 32'hC040_0000, 32'h4080_0000,
               32'h3F2A_AAAB, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000};
        tf = '{5'b00001, 5'b00000, 5'b00000, 5'b00000,
               5'b00001, 5'b00101, 5'b00101, 5'b00011};
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{td[i], tf[i], 27});
            send(ta[i], tb[i]);
            wait_valid(d, f, lat);
            e = sb.pop_front();
            compared += 3;
            if (d !== e.d) begin mismatched++; $display("FAIL normal[%0d] data: got %h want %h", i, d, e.d); end
            if (f !== e.f) begin mismatched++; $display("FAIL normal[%0d] flags: got %b want %b", i, f, e.f); end
            if (lat != e.lat) begin mismatched++; $display("FAIL normal[%0d] latency: got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_specials();
        logic [31:0] ta [9], tb [9], td [9];
        logic [4:0]  tf [9];
        logic [31:0] d; logic [4:0] f; int lat; exp_t e;
        ta = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 32'hBF80_0000,
               32'h0040_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'hC000_0000};
        tb = '{32'h0000_0000, 32'h8000_0000, 32'h4000_0000, 32'hFF80_0000, 32'h7F80_0000,
               32'h3F80_0000, 32'h3F80_0000, 32'h0040_0000, 32'h8000_0000};
        td = '{32'h7F80_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000,
               32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h7F80_0000};
        tf = '{5'b01000, 5'b10000, 5'b00000, 5'b10000, 5'b00000,
               5'b00000, 5'b10000, 5'b01000, 5'b01000};
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{td[i], tf[i], 1});
            send(ta[i], tb[i]);
            wait_valid(d, f, lat);
            e = sb.pop_front();
            compared += 3;
            if (d !== e.d) begin mismatched++; $display("FAIL special[%0d] data: got %h want %h", i, d, e.d); end
            if (f !== e.f) begin mismatched++; $display("FAIL special[%0d] flags: got %b want %b", i, f, e.f); end
            if (lat != e.lat) begin mismatched++; $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] d; logic [4:0] f; int lat; int nv; exp_t e;
        sb.push_back('{32'h4040_0000, 5'b00000, 27});
        send(32'h40C0_0000, 32'h4000_0000);
        wait_valid(d, f, lat);
        e = sb.pop_front();
        send(32'h3F80_0000, 32'h4040_0000);
        repeat (9) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL flush busy: got %b want 0", o_busy); end
        nv = 0;
        repeat (40) begin @(posedge i_clk); #1; if (o_valid) nv++; end
        compared += 3;
        if (nv != 0) begin mismatched++; $display("FAIL flush valid count: got %0d want 0", nv); end
        if (o_fpu_data !== e.d) begin mismatched++; $display("FAIL flush data held: got %h want %h", o_fpu_data, e.d); end
        if (o_fflags !== e.f) begin mismatched++; $display("FAIL flush flags held: got %b want %b", o_fflags, e.f); end
        i_start = 1'b1; i_flush = 1'b1; i_rs1_f = 32'h3F80_0000; i_rs2_f = 32'h0000_0000;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL flush+start busy: got %b want 0", o_busy); end
        nv = 0;
        repeat (10) begin @(posedge i_clk); #1; if (o_valid) nv++; end
        compared++;
        if (nv != 0) begin mismatched++; $display("FAIL flush+start valid count: got %0d want 0", nv); end
    endtask

    task automatic test_busy_start();
        logic [31:0] d; logic [4:0] f; int lat; int nv; int n; exp_t e;
        sb.push_back('{32'h4040_0000, 5'b00000, 27});
        send(32'h40C0_0000, 32'h4000_0000);
        repeat (4) @(posedge i_clk);
        #1 i_start = 1'b1; i_rs1_f = 32'h3F80_0000; i_rs2_f = 32'h0000_0000;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        nv = 0; lat = -1; d = '0; f = '0;
        for (n = 6; n <= 70; n++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                if (nv == 0) begin lat = n; d = o_fpu_data; f = o_fflags; end
                nv++;
            end
        end
        e = sb.pop_front();
        compared += 4;
        if (nv != 1) begin mismatched++; $display("FAIL busy start valid count: got %0d want 1", nv); end
        if (lat != e.lat) begin mismatched++; $display("FAIL busy start latency: got %0d want %0d", lat, e.lat); end
        if (d !== e.d) begin mismatched++; $display("FAIL busy start data: got %h want %h", d, e.d); end
        if (f !== e.f) begin mismatched++; $display("FAIL busy start flags: got %b want %b", f, e.f); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [4:0] f; int lat; exp_t e;
        sb.push_back('{32'h3EAA_AAAB, 5'b00001, 27});
        send(32'h3F80_0000, 32'h4040_0000);
        wait_valid(d, f, lat);
        e = sb.pop_front();
        compared += 2;
        if (d !== e.d) begin mismatched++; $display("FAIL b2b first data: got %h want %h", d, e.d); end
        if (lat != e.lat) begin mismatched++; $display("FAIL b2b first latency: got %0d want %0d", lat, e.lat); end
        @(posedge i_clk); #1;
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL b2b busy after done: got %b want 0", o_busy); end
        sb.push_back('{32'h7F80_0000, 5'b01000, 1});
        i_start = 1'b1; i_rs1_f = 32'h4000_0000; i_rs2_f = 32'h0000_0000;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_valid(d, f, lat);
        e = sb.pop_front();
        compared += 3;
        if (d !== e.d) begin mismatched++; $display("FAIL b2b second data: got %h want %h", d, e.d); end
        if (f !== e.f) begin mismatched++; $display("FAIL b2b second flags: got %b want %b", f, e.f); end
        if (lat != e.lat) begin mismatched++; $display("FAIL b2b second latency: got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [4:0] f; int lat; exp_t e;
        send(32'h3F80_0000, 32'h4040_0000);
        repeat (10) @(posedge i_clk);
        #3 i_reset = 1'b0;
        #1;
        compared += 4;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL mid reset busy: got %b want 0", o_busy); end
        if (o_valid !== 1'b0) begin mismatched++; $display("FAIL mid reset valid: got %b want 0", o_valid); end
        if (o_fpu_data !== 32'h0) begin mismatched++; $display("FAIL mid reset data: got %h want 00000000", o_fpu_data); end
        if (o_fflags !== 5'b0) begin mismatched++; $display("FAIL mid reset flags: got %b want 00000", o_fflags); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        sb.push_back('{32'h4040_0000, 5'b00000, 27});
        send(32'h40C0_0000, 32'h4000_0000);
        wait_valid(d, f, lat);
        e = sb.pop_front();
        compared += 3;
        if (d !== e.d) begin mismatched++; $display("FAIL post reset data: got %h want %h", d, e.d); end
        if (f !== e.f) begin mismatched++; $display("FAIL post reset flags: got %b want %b", f, e.f); end
        if (lat != e.lat) begin mismatched++; $display("FAIL post reset latency: got %0d want %0d", lat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_normals();
        test_specials();
        test_flush();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
